c_adder: RTL and testbench

C_ADDER -- requirements
Module: c_adder

---
 rtl/c_adder_if.sv | 12 +
 rtl/c_adder.sv | 98 +++++++++
 tb/tb_c_adder.sv | 135 +++++++++++++
 3 files changed

// File: rtl/c_adder_if.sv
// Operand/result bundle for the registered carry-lookahead adder.
// The master drives the operands; the slave returns the registered sum.
interface c_adder_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH:0]   sum;

    modport master (output a, output b, input sum);
    modport slave  (input a, input b, output sum);
endinterface

// File: rtl/c_adder.sv
// Registered unsigned adder built from a two-level carry-lookahead tree.
// Each 4-bit group exports its generate/propagate pair, and a second-level
// lookahead unit turns those pairs into the group carry-ins.
module c_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH:0]   sum
);
    localparam int NG = WIDTH / 4;

    generate
        if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
            $error("c_adder: WIDTH must be a multiple of 4 and at least 4");
        end
    endgenerate

    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] c;
    logic [NG-1:0]    gg;
    logic [NG-1:0]    gp;
    logic [NG:0]      gc;
    logic [WIDTH:0]   next_sum;

    // Fully expanded second-level carry into group j: a later group
    // carries in if some earlier group generates and every group in between propagates.
    function automatic logic group_carry(input int j,
                                         input logic [NG-1:0] ggv,
                                         input logic [NG-1:0] gpv);
        logic carry;
        logic term;
        carry = 1'b0;
        for (int k = 0; k < j; k++) begin
            term = ggv[k];
            for (int m = k + 1; m < j; m++) begin
                term = term & gpv[m];
            end
            carry = carry | term;
        end
        return carry;
    endfunction

    always_comb begin
        g = a & b;
        p = a ^ b;
    end

    always_comb begin
        gg = '0;
        gp = '0;
        for (int j = 0; j < NG; j++) begin
            gg[j] = g[4*j+3]
                  | (p[4*j+3] & g[4*j+2])
                  | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                  | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
            gp[j] = p[4*j+3] & p[4*j+2] & p[4*j+1] & p[4*j];
        end
    end

    // Carry-in to bit 0 is fixed at zero, so group 0 never receives a carry.
    always_comb begin
        gc = '0;
        for (int j = 1; j <= NG; j++) begin
            gc[j] = group_carry(j, gg, gp);
        end
    end

    always_comb begin
        c = '0;
        for (int j = 0; j < NG; j++) begin
            c[4*j]   = gc[j];
            c[4*j+1] = g[4*j] | (p[4*j] & gc[j]);
            c[4*j+2] = g[4*j+1]
                     | (p[4*j+1] & g[4*j])
                     | (p[4*j+1] & p[4*j] & gc[j]);
            c[4*j+3] = g[4*j+2]
                     | (p[4*j+2] & g[4*j+1])
                     | (p[4*j+2] & p[4*j+1] & g[4*j])
                     | (p[4*j+2] & p[4*j+1] & p[4*j] & gc[j]);
        end
    end

    always_comb begin
        next_sum = {gc[NG], p ^ c};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum <= '0;
        end else begin
            sum <= next_sum;
        end
    end
endmodule

// File: tb/tb_c_adder.sv
// Self-checking bench for c_adder: directed boundary cases, random streaming
// against a one-cycle-delayed arithmetic model, and a WIDTH=8 instance.
module tb_c_adder;
    logic        clk;
    logic        rst_n;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic [8:0]  sum8;
    logic [16:0] model;
    logic [16:0] held;
    int          total;
    int          bad;

    c_adder_if #(.WIDTH(16)) bus ();

    c_adder #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (bus.a),
        .b     (bus.b),
        .sum   (bus.sum)
    );

    c_adder #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a8),
        .b     (b8),
        .sum   (sum8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: whatever the adder should hold after each edge, from plain arithmetic.
    always @(posedge clk) begin
        if (!rst_n) model <= 17'h0;
        else        model <= {1'b0, bus.a} + {1'b0, bus.b};
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] na, input logic [15:0] nb,
                                 input logic nrst);
        @(negedge clk);
        bus.a = na;
        bus.b = nb;
        rst_n = nrst;
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.a = '0;
        bus.b = '0;
        a8    = 8'h00;
        b8    = 8'h00;

        applyStimulus(16'h1234, 16'h1111, 1'b0);
        checkOutput("reset_edge1", 32'(bus.sum), 32'h0);
        applyStimulus(16'h1234, 16'h1111, 1'b0);
        checkOutput("reset_edge2", 32'(bus.sum), 32'h0);
        applyStimulus(16'h1234, 16'h1111, 1'b1);
        checkOutput("reset_release", 32'(bus.sum), 32'h02345);

        applyStimulus(16'hFFFF, 16'hFFFF, 1'b1);
        checkOutput("max_plus_max", 32'(bus.sum), 32'h1FFFE);
        applyStimulus(16'hFFFF, 16'h0001, 1'b1);
        checkOutput("carry_out", 32'(bus.sum), 32'h10000);
        applyStimulus(16'h0000, 16'h0000, 1'b1);
        checkOutput("zero", 32'(bus.sum), 32'h0);
        applyStimulus(16'h0FFF, 16'h0001, 1'b1);
        checkOutput("group_ripple_3", 32'(bus.sum), 32'h01000);
        applyStimulus(16'h00F0, 16'h0010, 1'b1);
        checkOutput("group_ripple_1", 32'(bus.sum), 32'h00100);

        // Held operands: result must stay put edge after edge.
        applyStimulus(16'hA5A5, 16'h5A5B, 1'b1);
        checkOutput("hold_first", 32'(bus.sum), 32'h10000);
        held = bus.sum;
        applyStimulus(16'hA5A5, 16'h5A5B, 1'b1);
        checkOutput("hold_second", 32'(bus.sum), 32'(held));

        // A reset pulse between edges must not touch the register.
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        checkOutput("async_low", 32'(bus.sum), 32'h10000);
        rst_n = 1'b1;
        #1;
        checkOutput("async_high", 32'(bus.sum), 32'h10000);

        for (int i = 0; i < 30; i++) begin
            logic [15:0] ra;
            logic [15:0] rb;
            logic        rr;
            ra = 16'($urandom);
            rb = 16'($urandom);
            rr = (i == 15) ? 1'b0 : 1'b1;
            applyStimulus(ra, rb, rr);
            if (rr) begin
                checkOutput("stream_direct", 32'(bus.sum), {15'h0, {1'b0, ra} + {1'b0, rb}});
            end else begin
                checkOutput("stream_reset", 32'(bus.sum), 32'h0);
            end
            checkOutput("stream_model", 32'(bus.sum), 32'(model));
        end

        @(negedge clk);
        a8 = 8'hFF;
        b8 = 8'h01;
        @(posedge clk);
        #1;
        checkOutput("w8_carry", 32'(sum8), 32'h100);
        @(negedge clk);
        a8 = 8'h3C;
        b8 = 8'h0F;
        @(posedge clk);
        #1;
        checkOutput("w8_group", 32'(sum8), 32'h04B);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
